// File: rtl/stopwatch_disp_pkg.sv
// rtl/stopwatch_disp_pkg.sv - glyph codes, scan states and seven-segment decode
//
// Purpose: values shared by the stopwatch display blocks.
//   CODE_*        glyph codes (above the decimal digits) that the code muxes return
//   scan_state_t  BLANK / SHOW slot states of the scan driver
//   seg7_decode   4-bit glyph code -> active-low segments {g,f,e,d,c,b,a}
package stopwatch_disp_pkg;

  localparam logic [3:0] CODE_DASH     = 4'hA;
  localparam logic [3:0] CODE_E        = 4'hB;
  localparam logic [3:0] CODE_R        = 4'hC;
  localparam logic [3:0] CODE_ERR_ZERO = 4'hD;
  localparam logic [3:0] CODE_BLANK    = 4'hE;
  localparam logic [3:0] CODE_C        = 4'hF;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  // Segments are active-low: a 0 bit lights that segment.
  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:          seg = 7'h40;
      4'h1:          seg = 7'h79;
      4'h2:          seg = 7'h24;
      4'h3:          seg = 7'h30;
      4'h4:          seg = 7'h19;
      4'h5:          seg = 7'h12;
      4'h6:          seg = 7'h02;
      4'h7:          seg = 7'h78;
      4'h8:          seg = 7'h00;
      4'h9:          seg = 7'h10;
      CODE_DASH:     seg = 7'h3F;
      CODE_E:        seg = 7'h06;
      CODE_R:        seg = 7'h2F;
      CODE_ERR_ZERO: seg = 7'h40;
      CODE_BLANK:    seg = SEG_OFF;
      CODE_C:        seg = 7'h46;
      default:       seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational glyph-code to seven-segment decoder
//
// Purpose: thin wrapper around seg7_decode so any display block can drop it in.
// Ports:
//   code   in   4  glyph code
//   seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  assign seg_n = seg7_decode(code);

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - time-multiplexed 4-digit common-anode display driver
//
// Purpose: scans digits 0..3, asks the code muxes for each digit's glyph via s,
// latches the returned code after a one-cycle blanking gap and lights one anode.
// Optional macro SCAN_BLINK_EN: blink the whole display while error_in is high.
// Ports:
//   clk       in   1  system clock
//   rst_n     in   1  synchronous active-low reset
//   s         out  2  digit select to the code muxes (00 = rightmost)
//   y_in      in   4  glyph code for the current s
//   error_in  in   1  error level (only used with SCAN_BLINK_EN)
//   an_n      out  4  anode enables, active-low
//   seg_n     out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp_n      out  1  decimal point, active-low
module display_scan_driver
  import stopwatch_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 128,
  parameter int DP_DIGIT    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] s,
  input  logic [3:0] y_in,
  input  logic       error_in,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int            PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [1:0]    DP_SEL   = 2'(DP_DIGIT);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          lit_en;
  logic [6:0]    seg_dec;

  scan_state_t state, state_nx;
  logic [1:0]  s_nx;
  logic [3:0]  an_nx;
  logic [6:0]  seg_nx;
  logic        dp_nx;

  assign tick = (pre_cnt == PRE_LAST);

  seg7_decoder u_dec (
    .code  (y_in),
    .seg_n (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + 1'b1;
  end

`ifdef SCAN_BLINK_EN
  localparam int            BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge clk) begin
    if (!rst_n || !error_in) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Once error_in drops the slot being latched is lit even though blink_on
  // only returns high on this same edge.
  assign lit_en = blink_on | ~error_in;
`else
  // error_in only matters to the blink option; kept as a named sink.
  logic unused_error_in;
  assign unused_error_in = error_in;
  assign lit_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
      s     <= 2'b00;
      an_n  <= 4'b1111;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end else begin
      state <= state_nx;
      s     <= s_nx;
      an_n  <= an_nx;
      seg_n <= seg_nx;
      dp_n  <= dp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s;
    an_nx    = an_n;
    seg_nx   = seg_n;
    dp_nx    = dp_n;
    if (tick) begin
      // New slot: advance the select and go dark while the muxes settle.
      state_nx = BLANK;
      s_nx     = s + 2'd1;
      an_nx    = 4'b1111;
    end else if (state == BLANK) begin
      // y_in has had a full cycle to follow s; latch it for the whole slot.
      state_nx = SHOW;
      seg_nx   = seg_dec;
      if (lit_en) begin
        an_nx = ~(4'b0001 << s);
        dp_nx = ~(s == DP_SEL);
      end else begin
        an_nx = 4'b1111;
        dp_nx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - randomized scoreboard bench for display_scan_driver
module tb_display_scan_driver;

  localparam int R   = 4;
  localparam int BT  = 2;
  localparam int DPD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] s;
  logic [3:0] y_in = 4'h0;
  logic       error_in = 1'b0;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  display_scan_driver #(
    .REFRESH_DIV (R),
    .BLINK_TICKS (BT),
    .DP_DIGIT    (DPD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s),
    .y_in     (y_in),
    .error_in (error_in),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .dp_n     (dp_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic rst; logic [1:0] s; logic lit;} cyc_t;
  typedef struct packed {logic [3:0] an; logic [6:0] seg; logic dp;} slot_t;

  cyc_t  cyc_q[$];
  slot_t slot_q[$];
  int    vectors = 0;
  int    errors = 0;

  // Reference state: clock edges since reset, blink tick count and blink phase.
  int t = 0;
  int bc = 0;
  bit bon = 1'b1;
  bit slot_lit = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h06, 7'h2F, 7'h40, 7'h7F, 7'h46};
    return tbl[c];
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // One clock of stimulus. mode 0: digits 1..4, mode 1: error glyphs, else random.
  task automatic drive_cycle(input bit rst_v, input int mode, input bit err);
    int d;
    bit lit_en;
    @(negedge clk);
    rst_n    = rst_v;
    error_in = err;
    if (!rst_v) begin
      y_in     = 4'($urandom);
      t        = 0;
      bc       = 0;
      bon      = 1'b1;
      slot_lit = 1'b0;
      cyc_q.push_back('{rst: 1'b1, s: 2'd0, lit: 1'b0});
    end else begin
      d = (t / R) % 4;
      if (t % R == 0) begin
        case (mode)
          0:       y_in = 4'(d + 1);
          1:       y_in = (d == 3) ? 4'hF : 4'hD;
          default: y_in = 4'($urandom);
        endcase
        lit_en = 1'b1;
`ifdef SCAN_BLINK_EN
        lit_en = !err || bon;
`endif
        slot_lit = lit_en;
        if (lit_en)
          slot_q.push_back('{an: ~(4'b0001 << d), seg: ref_seg(y_in),
                             dp: (d == DPD) ? 1'b0 : 1'b1});
      end else begin
        y_in = 4'($urandom);
      end
`ifdef SCAN_BLINK_EN
      if (!err) begin
        bc  = 0;
        bon = 1'b1;
      end else if (t % R == R - 1) begin
        bc++;
        if (bc == BT) begin
          bc  = 0;
          bon = !bon;
        end
      end
`endif
      t++;
      cyc_q.push_back('{rst: 1'b0, s: 2'((t / R) % 4), lit: (t % R != 0) && slot_lit});
    end
  endtask

  initial begin
    cyc_t  ce;
    slot_t cur;
    bit    prev_lit;
    cur      = '0;
    prev_lit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() != 0) begin
        ce = cyc_q.pop_front();
        check("s", 16'(s), 16'(ce.s));
        if (ce.rst) begin
          check("reset outputs", 16'({an_n, seg_n, dp_n}), 16'({4'hF, 7'h7F, 1'b1}));
        end else if (!ce.lit) begin
          check("an_n dark", 16'(an_n), 16'hF);
        end else begin
          if (!prev_lit) begin
            if (slot_q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL slot_q: lit slot with no expectation at %0t", $time);
            end else begin
              cur = slot_q.pop_front();
            end
          end
          check("lit an_n/seg_n/dp_n", 16'({an_n, seg_n, dp_n}), 16'(cur));
        end
        prev_lit = ce.lit;
      end
    end
  end

  initial begin
    int found;
    repeat (3)  drive_cycle(1'b0, 2, 1'b0);
    repeat (16) drive_cycle(1'b1, 0, 1'b0);
    repeat (16) drive_cycle(1'b1, 1, 1'b0);
    repeat (32) drive_cycle(1'b1, 2, 1'b1);
    repeat (8)  drive_cycle(1'b1, 2, 1'b0);
    found = 0;
    for (int i = 0; i < 32 && found == 0; i++) begin
      if ((t / R) % 4 == 2 && t % R == 2) found = 1;
      else drive_cycle(1'b1, 2, 1'b0);
    end
    check("reached SHOW of s=2", 16'(found), 16'd1);
    drive_cycle(1'b0, 2, 1'b0);
    repeat (12)  drive_cycle(1'b1, 0, 1'b0);
    repeat (300) drive_cycle(1'b1, 2, ($urandom_range(0, 7) != 0));
    @(posedge clk);
    @(posedge clk);
    #2;
    check("cycle queue drained", 16'(cyc_q.size()), 16'd0);
    check("slot queue drained", 16'(slot_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
